// File: rtl/tinyriscv_pkg.sv
// Shared constants and types for the tinyriscv register file.
package tinyriscv_pkg;

    localparam int RegBus      = 32;   // register width
    localparam int RegAddrBus  = 5;    // register address width
    localparam int RegNum      = 32;   // number of architectural registers
    localparam logic WriteEnable = 1'b1;

    // Debug access port FSM: IDLE accepts requests, RESP drives the response pulse.
    typedef enum logic [0:0] {
        DBG_IDLE = 1'b0,
        DBG_RESP = 1'b1
    } dbg_state_e;

endpackage

// File: rtl/regfile_dbg_port.sv
// Debug access port: req/gnt/rvalid handshake with registered read data.
// Handshake: gnt is asserted in IDLE when req is high and the access does not
// collide with a core write (debug writes stall while the core writes); a grant
// at edge N produces exactly one rvalid cycle N+1, after which the port returns
// to IDLE. rdata holds the last captured response until the next grant.
module regfile_dbg_port
    import tinyriscv_pkg::*;
#(
    parameter int DataWidth = RegBus
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic                 core_we_i,
    input  logic [DataWidth-1:0] rd_val_i,
    output logic                 gnt_o,
    output logic                 wr_en_o,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output dbg_state_e           state_o
);

    dbg_state_e           state_q, state_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    // Next-state, grant and response capture.
    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        gnt_o    = 1'b0;
        rvalid_o = 1'b0;
        case (state_q)
            DBG_IDLE: begin
                gnt_o = req_i & ~(we_i & core_we_i);
                if (gnt_o) begin
                    state_d = DBG_RESP;
                    rdata_d = we_i ? '0 : rd_val_i;
                end
            end
            DBG_RESP: begin
                rvalid_o = 1'b1;
                state_d  = DBG_IDLE;
            end
            default: state_d = DBG_IDLE;
        endcase
        wr_en_o = gnt_o & we_i;
    end

    // State and response registers; a reset drops any in-flight access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DBG_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
    assign state_o = state_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NumRead combinational read ports with write-through
// bypass, one core write port, a debug access port, and an optional busy-bit
// scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
module regfile_mp
    import tinyriscv_pkg::*;
#(
    parameter int DataWidth = RegBus,
    parameter int AddrWidth = RegAddrBus,
    parameter int NumRead   = 2,
    parameter int ZeroReg   = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                we_i,
    input  logic [AddrWidth-1:0]                waddr_i,
    input  logic [DataWidth-1:0]                wdata_i,
    input  logic [NumRead-1:0][AddrWidth-1:0]   raddr_i,
    output logic [NumRead-1:0][DataWidth-1:0]   rdata_o,
    input  logic                                dbg_req_i,
    input  logic                                dbg_we_i,
    input  logic [AddrWidth-1:0]                dbg_addr_i,
    input  logic [DataWidth-1:0]                dbg_wdata_i,
    output logic                                dbg_gnt_o,
    output logic                                dbg_rvalid_o,
    output logic [DataWidth-1:0]                dbg_rdata_o,
    input  logic                                busy_set_i,
    input  logic [AddrWidth-1:0]                busy_addr_i,
    output logic [NumRead-1:0]                  rs_busy_o
);

    localparam int NumRegs = 2 ** AddrWidth;

    logic [DataWidth-1:0] regs_q [NumRegs];
    logic [DataWidth-1:0] regs_d [NumRegs];
    logic                 dbg_wr_en;
    logic [DataWidth-1:0] dbg_rd_val;
    dbg_state_e           dbg_fsm_state;

    // Register 0 is hardwired when ZeroReg is set.
    function automatic logic zero_blocked(input logic [AddrWidth-1:0] a);
        return (ZeroReg != 0) && (a == '0);
    endfunction

    // Core-visible value of a register, including write-through of the core write.
    function automatic logic [DataWidth-1:0] read_val(input logic [AddrWidth-1:0] a);
        if (zero_blocked(a))
            return '0;
        else if (we_i && (a == waddr_i))
            return wdata_i;
        else
            return regs_q[a];
    endfunction

    // Combinational read ports with bypass.
    always_comb begin
        for (int k = 0; k < NumRead; k++) begin
            rdata_o[k] = read_val(raddr_i[k]);
        end
        dbg_rd_val = read_val(dbg_addr_i);
    end

    // Storage update; core and debug writes never target one cycle together.
    always_comb begin
        regs_d = regs_q;
        if (we_i && !zero_blocked(waddr_i))
            regs_d[waddr_i] = wdata_i;
        if (dbg_wr_en && !zero_blocked(dbg_addr_i))
            regs_d[dbg_addr_i] = dbg_wdata_i;
    end

    // Register storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_dbg_port #(
        .DataWidth (DataWidth)
    ) u_dbg (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (dbg_req_i),
        .we_i      (dbg_we_i),
        .core_we_i (we_i),
        .rd_val_i  (dbg_rd_val),
        .gnt_o     (dbg_gnt_o),
        .wr_en_o   (dbg_wr_en),
        .rvalid_o  (dbg_rvalid_o),
        .rdata_o   (dbg_rdata_o),
        .state_o   (dbg_fsm_state)
    );

`ifdef REGFILE_SCOREBOARD_EN
    logic [NumRegs-1:0] busy_q, busy_d;

    // Busy bits: clear on writeback, set on issue; set wins on the same address.
    always_comb begin
        busy_d = busy_q;
        if (we_i)
            busy_d[waddr_i] = 1'b0;
        if (busy_set_i)
            busy_d[busy_addr_i] = 1'b1;
        if (ZeroReg != 0)
            busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A writeback in the current cycle resolves the hazard immediately.
    always_comb begin
        for (int k = 0; k < NumRead; k++) begin
            rs_busy_o[k] = busy_q[raddr_i[k]] & ~(we_i & (waddr_i == raddr_i[k]));
        end
    end

    logic unused_ok;
    assign unused_ok = ^{dbg_fsm_state};
`else
    assign rs_busy_o = '0;

    logic unused_ok;
    assign unused_ok = ^{dbg_fsm_state, busy_set_i, busy_addr_i};
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_regfile_mp;
    import tinyriscv_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              we = 1'b0;
    logic [4:0]        waddr = '0;
    logic [31:0]       wdata = '0;
    logic [1:0][4:0]   raddr = '0;
    logic [1:0][31:0]  rdata;
    logic              dbg_req = 1'b0;
    logic              dbg_we = 1'b0;
    logic [4:0]        dbg_addr = '0;
    logic [31:0]       dbg_wdata = '0;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;
    logic              busy_set = 1'b0;
    logic [4:0]        busy_addr = '0;
    logic [1:0]        rs_busy;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_resp;
    logic [31:0] m_drd;

    regfile_mp #(.DataWidth(32), .AddrWidth(5), .NumRead(2), .ZeroReg(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid),
        .dbg_rdata_o(dbg_rdata),
        .busy_set_i(busy_set), .busy_addr_i(busy_addr), .rs_busy_o(rs_busy)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model view of a register as the core sees it this cycle.
    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (we && a == waddr) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic m_rs_busy(input logic [4:0] a);
`ifdef REGFILE_SCOREBOARD_EN
        return m_busy[a] && !(we && waddr == a);
`else
        return 1'b0;
`endif
    endfunction

    // Compare DUT with model mid-cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_busy = '0;
            m_resp = 1'b0;
            m_drd  = '0;
            check("rst_gnt", dbg_gnt, 0);
            check("rst_rvalid", dbg_rvalid, 0);
            check("rst_drdata", dbg_rdata, 0);
            check("rst_rs_busy", rs_busy, 0);
        end else begin
            logic g;
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rdata%0d", k), rdata[k], m_rd(raddr[k]));
                check($sformatf("rs_busy%0d", k), rs_busy[k], m_rs_busy(raddr[k]));
            end
            g = !m_resp && dbg_req && !(dbg_we && we);
            check("gnt", dbg_gnt, g);
            check("rvalid", dbg_rvalid, m_resp);
            check("drdata", dbg_rdata, m_drd);
            if (g) m_drd = dbg_we ? 32'h0 : m_rd(dbg_addr);
            if (g && dbg_we && dbg_addr != 0) m_regs[dbg_addr] = dbg_wdata;
            if (we && waddr != 0) m_regs[waddr] = wdata;
            if (we) m_busy[waddr] = 1'b0;
            if (busy_set) m_busy[busy_addr] = 1'b1;
            m_busy[0] = 1'b0;
            m_resp = g;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin : main
        int n;
        // Reset phase
        repeat (3) step();
        rst_n = 1'b1;

        // All registers read zero after reset
        for (int i = 1; i < 32; i++) begin
            raddr[0] = 5'(i);
            raddr[1] = 5'(32 - i);
            neg();
            if (i == 1 || i == 31) begin
                check("rst_x_p0", rdata[0], 32'h0);
                check("rst_x_p1", rdata[1], 32'h0);
            end
            step();
        end

        // x0 write is ignored and never bypassed
        we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF; raddr[0] = 5'd0; raddr[1] = 5'd0;
        neg(); check("x0_bypass", rdata[0], 32'h0);
        step(); we = 1'b0;
        neg(); check("x0_after", rdata[1], 32'h0);
        step();

        // Write-through bypass
        we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; raddr[0] = 5'd5; raddr[1] = 5'd5;
        neg(); check("bypass_p0", rdata[0], 32'h12345678); check("bypass_p1", rdata[1], 32'h12345678);
        step(); we = 1'b0;
        neg(); check("stored_x5", rdata[0], 32'h12345678);
        step();

        // Debug write stalled by three core-write cycles
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'hA5A5A5A5;
        we = 1'b1; waddr = 5'd10; wdata = 32'h1;
        for (int c = 0; c < 3; c++) begin
            neg(); check("dbgw_stall", dbg_gnt, 0);
            step();
        end
        we = 1'b0;
        neg(); check("dbgw_gnt", dbg_gnt, 1);
        step(); dbg_req = 1'b0; raddr[0] = 5'd7;
        neg(); check("dbgw_rvalid", dbg_rvalid, 1); check("dbgw_rdata", dbg_rdata, 0);
        check("dbgw_core_vis", rdata[0], 32'hA5A5A5A5);
        step();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
        neg(); check("dbgr_gnt", dbg_gnt, 1);
        step(); dbg_req = 1'b0;
        neg(); check("dbgr_rvalid", dbg_rvalid, 1); check("dbgr_x7", dbg_rdata, 32'hA5A5A5A5);
        step();
        neg(); check("dbgr_hold", dbg_rdata, 32'hA5A5A5A5); check("dbgr_pulse", dbg_rvalid, 0);
        step();

        // Debug read racing a core write to the same register
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h55;
        neg(); check("race_gnt", dbg_gnt, 1);
        step(); dbg_req = 1'b0; we = 1'b0;
        neg(); check("race_rvalid", dbg_rvalid, 1); check("race_rdata", dbg_rdata, 32'h55);
        step();

`ifdef REGFILE_SCOREBOARD_EN
        // Scoreboard set / clear / set-wins
        busy_set = 1'b1; busy_addr = 5'd3;
        step(); busy_set = 1'b0; raddr[0] = 5'd3;
        neg(); check("sb_set", rs_busy[0], 1);
        step(); we = 1'b1; waddr = 5'd3; wdata = 32'h3;
        neg(); check("sb_clr_same", rs_busy[0], 0);
        step(); we = 1'b0;
        neg(); check("sb_clr_after", rs_busy[0], 0);
        step(); busy_set = 1'b1; busy_addr = 5'd3; we = 1'b1; waddr = 5'd3;
        step(); busy_set = 1'b0; we = 1'b0;
        neg(); check("sb_set_wins", rs_busy[0], 1);
        step();
`endif

        // Reset while the debug port is responding
        we = 1'b1; waddr = 5'd4; wdata = 32'hCAFE0004;
        step(); we = 1'b0; raddr[0] = 5'd4;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd4;
        neg(); check("rr_gnt", dbg_gnt, 1);
        step(); dbg_req = 1'b0;
        check("rr_resp", dbg_rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("rr_rvalid0", dbg_rvalid, 0);
        check("rr_fsm_idle", dut.dbg_fsm_state, DBG_IDLE);
        check("rr_regs0", rdata[0], 32'h0);
        check("rr_drdata0", dbg_rdata, 32'h0);
        step(); rst_n = 1'b1;
        neg(); check("rr_x4_after", rdata[0], 32'h0); check("rr_no_rvalid", dbg_rvalid, 0);
        step();

        // Randomized traffic, checked every cycle by the compare process
        n = 0;
        for (int c = 0; c < 800; c++) begin
            logic g;
            neg();
            g = dbg_gnt;
            step();
            we        = ($urandom_range(0, 2) == 0);
            waddr     = 5'($urandom_range(0, 7));
            wdata     = $urandom;
            raddr[0]  = 5'($urandom_range(0, 7));
            raddr[1]  = 5'($urandom_range(0, 7));
            busy_set  = ($urandom_range(0, 3) == 0);
            busy_addr = 5'($urandom_range(0, 7));
            if (dbg_req && g) begin
                dbg_req = 1'b0;
                n++;
            end
            if (!dbg_req && $urandom_range(0, 2) == 0) begin
                dbg_req   = 1'b1;
                dbg_we    = $urandom_range(0, 1) == 1;
                dbg_addr  = 5'($urandom_range(0, 7));
                dbg_wdata = $urandom;
            end
        end
        dbg_req = 1'b0;
        step();
        checks++;
        if (n < 20) begin
            errors++;
            $display("FAIL dbg_progress: got %0d grants expected at least 20", n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
